// File: rtl/cpu_seq_ws_if.sv
// Bus between the mcpu datapath/memory side (master) and the instruction-cycle sequencer (slave).
// Carries decode inputs, the mem_req/mem_rdy handshake and the sequencer status outputs.
interface cpu_seq_ws_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             hlt;
    logic             step;
    logic             need_exerd;
    logic             need_load;
    logic             irq;
    logic             ie;
    logic             mem_rdy;
    logic             clr_fault;
    logic [3:0]       q;
    logic             mem_req;
    logic             busy;
    logic             fault;
    logic             irq_ack;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output run, hlt, step, need_exerd, need_load, irq, ie, mem_rdy, clr_fault,
        input  q, mem_req, busy, fault, irq_ack, instr_done, instr_cnt
    );

    modport slave (
        input  run, hlt, step, need_exerd, need_load, irq, ie, mem_rdy, clr_fault,
        output q, mem_req, busy, fault, irq_ack, instr_done, instr_cnt
    );
endinterface

// File: rtl/cpu_seq_ws.sv
// Instruction-cycle sequencer for the mcpu core with memory wait states, bus timeout,
// single-step, interrupt entry and a sticky bus-fault state; q drives the datapath enables.
module cpu_seq_ws #(
    parameter int TIMEOUT = 16,
    parameter int WCNT_W  = 5,
    parameter int CNT_W   = 16
) (
    input logic         clk,
    input logic         rst_n,
    cpu_seq_ws_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_OPCFT = 4'd1,
        S_OPLRD = 4'd2,
        S_OPLFT = 4'd3,
        S_ADRD  = 4'd4,
        S_EXERD = 4'd5,
        S_EXE   = 4'd6,
        S_LDRD  = 4'd7,
        S_LOAD  = 4'd8,
        S_IRQ   = 4'd9,
        S_FAULT = 4'd10
    } state_e;

    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_e            state_q;
    state_e            state_d;
    state_e            after_retire;
    logic [WCNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_wait;
    logic              timeout_hit;
    logic              retire;

    // Memory-read wait states; only these look at mem_rdy.
    assign in_wait     = (state_q == S_OPLRD) || (state_q == S_ADRD) ||
                         (state_q == S_EXERD) || (state_q == S_LDRD);
    assign timeout_hit = (TIMEOUT > 0) && (wcnt_q == WCNT_W'(TO_LAST));

    // Where a non-halting retire goes: interrupt entry first, then single-step.
    always_comb begin
        after_retire = S_OPCFT;
        if (bus.irq && bus.ie) begin
            after_retire = S_IRQ;
        end else if (bus.step) begin
            after_retire = S_IDLE;
        end
    end

    // NOTE: every output of a combinational block gets a default before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_IDLE:  if (bus.run) state_d = S_OPCFT;
            S_OPCFT: state_d = S_OPLRD;
            S_OPLRD: begin
                if (bus.mem_rdy)      state_d = S_OPLFT;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_OPLFT: state_d = S_ADRD;
            S_ADRD: begin
                if (bus.mem_rdy)      state_d = bus.need_exerd ? S_EXERD : S_EXE;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_EXERD: begin
                if (bus.mem_rdy)      state_d = S_EXE;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_EXE: begin
                // hlt outranks both the load phase and a pending interrupt.
                if (bus.hlt) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.need_load) begin
                    state_d = S_LDRD;
                end else begin
                    retire  = 1'b1;
                    state_d = after_retire;
                end
            end
            S_LDRD: begin
                if (bus.mem_rdy)      state_d = S_LOAD;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_LOAD: begin
                retire  = 1'b1;
                state_d = after_retire;
            end
            S_IRQ:   state_d = bus.step ? S_IDLE : S_OPCFT;
            S_FAULT: if (bus.clr_fault) state_d = S_IDLE;
            default: state_d = S_FAULT;
        endcase
    end

    // NOTE: reset is asynchronous and active-low so the sequencer drops to IDLE
    // at once, even in the middle of an instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
        end
    end

    // The counter restarts outside wait states and on every ready, so each
    // wait state is entered with a zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else if (in_wait && !bus.mem_rdy) begin
            wcnt_q <= wcnt_q + 1'b1;
        end else begin
            wcnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.q          = state_q;
    assign bus.mem_req    = in_wait;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign bus.fault      = (state_q == S_FAULT);
    assign bus.irq_ack    = (state_q == S_IRQ);
    assign bus.instr_done = retire;
    assign bus.instr_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_seq_ws.sv
// Randomised scoreboard bench for cpu_seq_ws: an instruction-level model emits the expected
// per-cycle response into a queue, a negedge monitor pops and compares against the DUT.
module tb_cpu_seq_ws;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [3:0]       q;
        logic             mem_req;
        logic             busy;
        logic             fault;
        logic             irq_ack;
        logic             instr_done;
        logic [CNT_W-1:0] cnt;
    } resp_t;

    logic clk;
    logic rst_n;

    cpu_seq_ws_if #(.CNT_W(CNT_W)) bus();

    cpu_seq_ws #(.TIMEOUT(TIMEOUT), .WCNT_W(5), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    resp_t            exp_q[$];
    int unsigned      n_vec = 0;
    int unsigned      n_err = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               at_idle = 1'b1;
    bit i_exerd, i_load, i_hlt, i_irq, i_ie, i_step;

    task automatic check(input string name, input resp_t act, input resp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got q=%0d req=%b busy=%b flt=%b ack=%b done=%b cnt=%0d, want q=%0d req=%b busy=%b flt=%b ack=%b done=%b cnt=%0d",
                     name, $time, act.q, act.mem_req, act.busy, act.fault, act.irq_ack,
                     act.instr_done, act.cnt, exp.q, exp.mem_req, exp.busy, exp.fault,
                     exp.irq_ack, exp.instr_done, exp.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            resp_t e;
            resp_t a;
            e = exp_q.pop_front();
            a.q          = bus.q;
            a.mem_req    = bus.mem_req;
            a.busy       = bus.busy;
            a.fault      = bus.fault;
            a.irq_ack    = bus.irq_ack;
            a.instr_done = bus.instr_done;
            a.cnt        = bus.instr_cnt;
            check("cycle", a, e);
        end
    end

    // One clock in state 'code'. Inputs not sampled in that state are randomised;
    // ctl is run in IDLE, clr_fault in FAULT and mem_rdy in a wait state.
    task automatic cyc(input logic [3:0] code, input bit ctl, input bit done);
        resp_t e;
        bus.run        = 1'($urandom);
        bus.hlt        = 1'($urandom);
        bus.step       = 1'($urandom);
        bus.need_exerd = 1'($urandom);
        bus.need_load  = 1'($urandom);
        bus.irq        = 1'($urandom);
        bus.ie         = 1'($urandom);
        bus.mem_rdy    = 1'($urandom);
        bus.clr_fault  = 1'($urandom);
        case (code)
            4'd0:                   bus.run = ctl;
            4'd10:                  bus.clr_fault = ctl;
            4'd2, 4'd5, 4'd7:       bus.mem_rdy = ctl;
            4'd4: begin
                bus.mem_rdy    = ctl;
                bus.need_exerd = i_exerd;
            end
            4'd6: begin
                bus.hlt       = i_hlt;
                bus.need_load = i_load;
                bus.irq       = i_irq;
                bus.ie        = i_ie;
                bus.step      = i_step;
            end
            4'd8: begin
                bus.irq  = i_irq;
                bus.ie   = i_ie;
                bus.step = i_step;
            end
            4'd9:                   bus.step = i_step;
            default: ;
        endcase
        e.q          = code;
        e.mem_req    = (code == 4'd2) || (code == 4'd4) || (code == 4'd5) || (code == 4'd7);
        e.busy       = (code != 4'd0) && (code != 4'd10);
        e.fault      = (code == 4'd10);
        e.irq_ack    = (code == 4'd9);
        e.instr_done = done;
        e.cnt        = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (done) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic fault_recover();
        int n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) cyc(4'd10, 1'b0, 1'b0);
        cyc(4'd10, 1'b1, 1'b0);
        at_idle = 1'b1;
    endtask

    // w idle cycles then ready; a wait of TIMEOUT or more ends in FAULT instead.
    task automatic wait_phase(input logic [3:0] code, input int w, output bit faulted);
        faulted = 1'b0;
        if (w >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) cyc(code, 1'b0, 1'b0);
            faulted = 1'b1;
            fault_recover();
        end else begin
            for (int i = 0; i < w; i++) cyc(code, 1'b0, 1'b0);
            cyc(code, 1'b1, 1'b0);
        end
    endtask

    task automatic instr(input int w_op, input int w_ad, input int w_ex, input int w_ld);
        bit f;
        if (at_idle) begin
            int gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) cyc(4'd0, 1'b0, 1'b0);
            cyc(4'd0, 1'b1, 1'b0);
        end
        at_idle = 1'b0;
        cyc(4'd1, 1'b0, 1'b0);
        wait_phase(4'd2, w_op, f);
        if (f) return;
        cyc(4'd3, 1'b0, 1'b0);
        wait_phase(4'd4, w_ad, f);
        if (f) return;
        if (i_exerd) begin
            wait_phase(4'd5, w_ex, f);
            if (f) return;
        end
        if (i_hlt) begin
            cyc(4'd6, 1'b0, 1'b1);
            at_idle = 1'b1;
            return;
        end
        if (!i_load) begin
            cyc(4'd6, 1'b0, 1'b1);
        end else begin
            cyc(4'd6, 1'b0, 1'b0);
            wait_phase(4'd7, w_ld, f);
            if (f) return;
            cyc(4'd8, 1'b0, 1'b1);
        end
        if (i_irq && i_ie) cyc(4'd9, 1'b0, 1'b0);
        at_idle = i_step;
    endtask

    task automatic set_ops(input bit ex, input bit ld, input bit h, input bit ir,
                           input bit en, input bit st);
        i_exerd = ex; i_load = ld; i_hlt = h; i_irq = ir; i_ie = en; i_step = st;
    endtask

    // Reset asserted away from the clock edge; the response must be IDLE in the same cycle.
    task automatic async_reset();
        rst_n = 1'b0;
        m_cnt = '0;
        cyc(4'd0, 1'($urandom), 1'b0);
        rst_n   = 1'b1;
        at_idle = 1'b1;
    endtask

    function automatic int rand_wait();
        int r = $urandom_range(0, 39);
        if (r < 32) return r % 4;
        if (r < 36) return TIMEOUT - 1;
        if (r < 38) return TIMEOUT - 2;
        return TIMEOUT;
    endfunction

    initial begin
        rst_n = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0);
        #2;
        @(posedge clk);
        #1;
        cyc(4'd0, 1'b1, 1'b0);
        async_reset();

        // Straight-line instructions, no waits.
        for (int i = 0; i < 3; i++) instr(0, 0, 0, 0);
        // Full operand + load path.
        set_ops(1, 1, 0, 0, 0, 0);
        instr(0, 0, 0, 0);
        // Three wait cycles in OPLRD, then the longest legal wait in each phase.
        set_ops(0, 0, 0, 0, 0, 0);
        instr(3, 0, 0, 0);
        set_ops(1, 1, 0, 0, 0, 0);
        instr(TIMEOUT - 1, TIMEOUT - 1, TIMEOUT - 1, TIMEOUT - 1);
        // Timeout in ADRD, then clear the fault.
        set_ops(0, 0, 0, 0, 0, 0);
        instr(0, TIMEOUT, 0, 0);
        // Single-step with interrupt entry, then restart from IDLE.
        set_ops(0, 0, 0, 1, 1, 1);
        instr(0, 0, 0, 0);
        set_ops(0, 0, 0, 0, 0, 0);
        instr(0, 0, 0, 0);
        // hlt beats irq and need_load.
        set_ops(0, 1, 1, 1, 1, 0);
        instr(1, 0, 0, 0);
        // Reset while waiting in LDRD.
        set_ops(0, 1, 0, 0, 0, 0);
        cyc(4'd0, 1'b1, 1'b0);
        cyc(4'd1, 1'b0, 1'b0);
        cyc(4'd2, 1'b1, 1'b0);
        cyc(4'd3, 1'b0, 1'b0);
        cyc(4'd4, 1'b1, 1'b0);
        cyc(4'd6, 1'b0, 1'b0);
        cyc(4'd7, 1'b0, 1'b0);
        cyc(4'd7, 1'b0, 1'b0);
        async_reset();
        instr(TIMEOUT - 1, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            set_ops(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 3) == 0));
            instr(rand_wait(), rand_wait(), rand_wait(), rand_wait());
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
